// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the single-cycle core's data side and a handshaked
// word-wide memory port: store strobes/lane replication, load lane extract/extend.
module lsu_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WriteData,
  input  logic [1:0]        MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        LdSize,
  input  logic              LdUnsigned,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              MisalignFault,
  output logic              BusError,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SZ_B = 2'b01;
  localparam logic [1:0] SZ_H = 2'b10;
  localparam logic [1:0] SZ_W = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic             uns_q;

  logic        is_store, is_load, access, aligned;
  logic [1:0]  acc_size;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic        start, misalign, ld_capture, tmo, stall_c;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;

  // Access decode: a store takes priority over a simultaneous load.
  always_comb begin
    is_store = (MemWrite != 2'b00);
    is_load  = MemRead & ~is_store;
    access   = is_store | is_load;
    acc_size = is_store ? MemWrite : ((LdSize == 2'b00) ? SZ_W : LdSize);
    aligned  = 1'b1;
    strb_d   = 4'b1111;
    wdata_d  = WriteData;
    case (acc_size)
      SZ_B: begin
        strb_d  = 4'(4'b0001 << Addr[1:0]);
        wdata_d = {4{WriteData[7:0]}};
      end
      SZ_H: begin
        aligned = ~Addr[0];
        strb_d  = 4'(4'b0011 << Addr[1:0]);
        wdata_d = {2{WriteData[15:0]}};
      end
      default: aligned = (Addr[1:0] == 2'b00);
    endcase
  end

  // Load lane selection and extension from the latched offset/size.
  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (off_q)
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      2'd3:    rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_B:    ld_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_H:    ld_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next state; completion is checked before the timeout so a late response still counts.
  always_comb begin
    state_d    = state;
    start      = 1'b0;
    misalign   = 1'b0;
    ld_capture = 1'b0;
    tmo        = 1'b0;
    stall_c    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            stall_c = 1'b1;
            start   = 1'b1;
            state_d = REQ;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (mem_gnt && mem_we) begin
          state_d = DONE;
        end else if (mem_gnt && mem_rvalid) begin
          ld_capture = 1'b1;
          state_d    = DONE;
        end else if (cnt == CNT_LAST) begin
          tmo     = 1'b1;
          state_d = DONE;
        end else if (mem_gnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        stall_c = 1'b1;
        if (mem_rvalid) begin
          ld_capture = 1'b1;
          state_d    = DONE;
        end else if (cnt == CNT_LAST) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Stall   = stall_c & Reset;
  assign mem_req = (state == REQ);

  // Request latch, timeout counter, load result and event pulses.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt           <= '0;
      size_q        <= 2'b00;
      off_q         <= 2'b00;
      uns_q         <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 32'h0;
      mem_wstrb     <= 4'h0;
      ReadData      <= 32'h0;
      MisalignFault <= 1'b0;
      BusError      <= 1'b0;
    end else begin
      MisalignFault <= misalign;
      BusError      <= tmo;
      if (start) begin
        cnt       <= '0;
        size_q    <= acc_size;
        off_q     <= Addr[1:0];
        uns_q     <= LdUnsigned;
        mem_we    <= is_store;
        mem_addr  <= {Addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= wdata_d;
        mem_wstrb <= strb_d;
      end else if (state == REQ || state == RESP) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (ld_capture)  ReadData <= ld_ext;
      else if (tmo)    ReadData <= 32'h0;
    end
  end

endmodule
